// File: rtl/wavetable_pkg.sv
// Shared encodings and constants for the polyphonic wavetable oscillator.
package wavetable_pkg;

  localparam logic [1:0] CFG_FS    = 2'd0;
  localparam logic [1:0] CFG_STEP  = 2'd1;
  localparam logic [1:0] CFG_BANK  = 2'd2;
  localparam logic [1:0] CFG_LEVEL = 2'd3;

  localparam int unsigned LEVEL_UNITY = 16;
  localparam int unsigned LEVEL_SHIFT = 4;
  localparam int unsigned LEVEL_W     = 5;
  localparam int unsigned STEP_W      = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_MIX     = 2'd3
  } sched_state_t;

endpackage

// File: rtl/wt_voice_ctrl.sv
// Per-voice control: sample-period divider, request/overrun tracking,
// phase accumulator, shadowed bank select and sub-octave toggle.
module wt_voice_ctrl
  import wavetable_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = 8,
  parameter int unsigned BANKWIDTH = 2,
  parameter int unsigned DIVWIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_sel,
  input  logic [DIVWIDTH-1:0]  cfg_data,
  input  logic                 grant,
  input  logic                 advance,
  output logic                 req_c,
  output logic [ADDRWIDTH-1:0] phase,
  output logic [BANKWIDTH-1:0] bank,
  output logic [LEVEL_W-1:0]   level,
  output logic                 sub_out,
  output logic                 overrun
);

  logic [DIVWIDTH-1:0]  fs;
  logic [DIVWIDTH-1:0]  cnt;
  logic [STEP_W-1:0]    step;
  logic [BANKWIDTH-1:0] shadow;
  logic                 pending;
  logic                 tick_c;
  logic [ADDRWIDTH:0]   phase_sum_c;

  assign tick_c      = enable && (fs != '0) && (cnt >= fs);
  assign req_c       = pending | tick_c;
  assign phase_sum_c = {1'b0, phase} + (ADDRWIDTH+1)'(step) + (ADDRWIDTH+1)'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      fs      <= '0;
      cnt     <= '0;
      step    <= '0;
      shadow  <= '0;
      bank    <= '0;
      level   <= '0;
      phase   <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
      sub_out <= 1'b0;
    end else begin
      if (cfg_we) begin
        case (cfg_sel)
          CFG_FS:    fs     <= cfg_data;
          CFG_STEP:  step   <= cfg_data[STEP_W-1:0];
          CFG_BANK:  shadow <= cfg_data[BANKWIDTH-1:0];
          CFG_LEVEL: level  <= cfg_data[LEVEL_W-1:0];
          default:   ;
        endcase
      end
      if (enable && (fs != '0)) begin
        cnt <= tick_c ? '0 : cnt + DIVWIDTH'(1);
      end
      // A tick coinciding with the grant is absorbed by that grant.
      pending <= grant ? 1'b0 : req_c;
      overrun <= overrun | (tick_c & pending);
      if (advance) begin
        phase <= phase_sum_c[ADDRWIDTH-1:0];
        if (phase_sum_c[ADDRWIDTH]) begin
          sub_out <= ~sub_out;
          bank    <= shadow;
        end
      end
    end
  end

endmodule

// File: rtl/wavetable_poly.sv
// Multi-voice wavetable oscillator: round-robin RAM read scheduler plus a
// level-scaled, saturating offset-binary mixer.
module wavetable_poly
  import wavetable_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned ADDRWIDTH = 8,
  parameter int unsigned BANKWIDTH = 2,
  parameter int unsigned NVOICES   = 4,
  parameter int unsigned DIVWIDTH  = 16,
  parameter int unsigned VW        = $clog2(NVOICES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 cfg_we,
  input  logic [VW-1:0]        cfg_voice,
  input  logic [1:0]           cfg_sel,
  input  logic [DIVWIDTH-1:0]  cfg_data,
  output logic [ADDRWIDTH-1:0] RADDR,
  output logic [BANKWIDTH-1:0] rbank,
  output logic                 RCLK,
  input  logic [DATAWIDTH-1:0] RDATA,
  output logic [DATAWIDTH-1:0] dout,
  output logic                 dout_valid,
  output logic [NVOICES-1:0]   SUB_OUT,
  output logic [NVOICES-1:0]   overrun
);

  localparam int unsigned SUMW  = DATAWIDTH + VW + 1;
  localparam int unsigned PRODW = DATAWIDTH + LEVEL_W + 1;
  localparam logic signed [DATAWIDTH-1:0] D_MAX    = {1'b0, {(DATAWIDTH-1){1'b1}}};
  localparam logic signed [DATAWIDTH-1:0] D_MIN    = {1'b1, {(DATAWIDTH-1){1'b0}}};
  localparam logic        [DATAWIDTH-1:0] MSB_MASK = {1'b1, {(DATAWIDTH-1){1'b0}}};

  sched_state_t state, state_nx;

  logic [NVOICES-1:0]          req_c;
  logic [NVOICES-1:0]          grant_c;
  logic [NVOICES-1:0]          advance_c;
  logic                        issue_c;
  logic                        mix_c;
  logic [ADDRWIDTH-1:0]        phase    [NVOICES];
  logic [BANKWIDTH-1:0]        bank     [NVOICES];
  logic [LEVEL_W-1:0]          level    [NVOICES];
  logic signed [DATAWIDTH-1:0] sample   [NVOICES];
  logic signed [DATAWIDTH-1:0] scaled_c [NVOICES];
  logic [VW-1:0]               cur;
  logic [VW-1:0]               last;
  logic [VW-1:0]               sel_c;
  logic                        sel_found_c;
  logic signed [SUMW-1:0]      sum_c;
  logic signed [DATAWIDTH-1:0] sat_c;

  for (genvar g = 0; g < NVOICES; g++) begin : g_voice
    logic [LEVEL_W-1:0]      lvl_c;
    logic signed [PRODW-1:0] prod_c;

    wt_voice_ctrl #(
      .ADDRWIDTH (ADDRWIDTH),
      .BANKWIDTH (BANKWIDTH),
      .DIVWIDTH  (DIVWIDTH)
    ) u_voice (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .cfg_we   (cfg_we && (cfg_voice == VW'(g))),
      .cfg_sel  (cfg_sel),
      .cfg_data (cfg_data),
      .grant    (grant_c[g]),
      .advance  (advance_c[g]),
      .req_c    (req_c[g]),
      .phase    (phase[g]),
      .bank     (bank[g]),
      .level    (level[g]),
      .sub_out  (SUB_OUT[g]),
      .overrun  (overrun[g])
    );

    assign lvl_c       = (level[g] > LEVEL_W'(LEVEL_UNITY)) ? LEVEL_W'(LEVEL_UNITY) : level[g];
    assign prod_c      = PRODW'(sample[g]) * PRODW'(signed'({1'b0, lvl_c}));
    assign scaled_c[g] = DATAWIDTH'(prod_c >>> LEVEL_SHIFT);
  end

  // Round-robin pick, searching from the voice after the last one serviced.
  always_comb begin
    sel_c       = last;
    sel_found_c = 1'b0;
    for (int i = 1; i <= int'(NVOICES); i++) begin
      if (!sel_found_c && req_c[last + VW'(i)]) begin
        sel_c       = last + VW'(i);
        sel_found_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (enable && sel_found_c) state_nx = S_ISSUE;
      S_ISSUE:   state_nx = S_CAPTURE;
      S_CAPTURE: state_nx = S_MIX;
      S_MIX:     state_nx = (enable && sel_found_c) ? S_ISSUE : S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    grant_c   = '0;
    advance_c = '0;
    issue_c   = 1'b0;
    mix_c     = 1'b0;
    if ((state == S_IDLE || state == S_MIX) && state_nx == S_ISSUE) begin
      issue_c        = 1'b1;
      grant_c[sel_c] = 1'b1;
    end
    if (state == S_CAPTURE) advance_c[cur] = 1'b1;
    if (state == S_MIX)     mix_c = 1'b1;
  end

  // Wide sum of every voice's held scaled sample, clamped to the signed range.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(NVOICES); i++) begin
      sum_c = sum_c + SUMW'(scaled_c[i]);
    end
    if (sum_c > SUMW'(D_MAX))      sat_c = D_MAX;
    else if (sum_c < SUMW'(D_MIN)) sat_c = D_MIN;
    else                           sat_c = DATAWIDTH'(sum_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      RADDR      <= '0;
      rbank      <= '0;
      RCLK       <= 1'b0;
      dout       <= MSB_MASK;
      dout_valid <= 1'b0;
      cur        <= '0;
      last       <= '1;
      for (int i = 0; i < int'(NVOICES); i++) sample[i] <= '0;
    end else begin
      RCLK       <= issue_c;
      dout_valid <= mix_c;
      if (issue_c) begin
        RADDR <= phase[sel_c];
        rbank <= bank[sel_c];
        cur   <= sel_c;
        last  <= sel_c;
      end
      if (state == S_CAPTURE) sample[cur] <= RDATA;
      if (mix_c) dout <= sat_c ^ MSB_MASK;
    end
  end

endmodule

// File: tb/tb_wavetable_poly.sv
// Directed bench for wavetable_poly with a {bank,addr} / constant RAM model.
module tb_wavetable_poly;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_voice = 2'd0;
  logic [1:0]  cfg_sel = 2'd0;
  logic [15:0] cfg_data = 16'd0;
  logic [7:0]  RADDR;
  logic [1:0]  rbank;
  logic        RCLK;
  logic [15:0] RDATA = 16'd0;
  logic [15:0] dout;
  logic        dout_valid;
  logic [3:0]  SUB_OUT;
  logic [3:0]  overrun;

  logic        ram_const_en = 1'b0;
  logic [15:0] ram_const = 16'd0;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  wavetable_poly dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .cfg_we     (cfg_we),
    .cfg_voice  (cfg_voice),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .RADDR      (RADDR),
    .rbank      (rbank),
    .RCLK       (RCLK),
    .RDATA      (RDATA),
    .dout       (dout),
    .dout_valid (dout_valid),
    .SUB_OUT    (SUB_OUT),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge RCLK) RDATA <= ram_const_en ? ram_const : 16'({rbank, RADDR});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset;
    rst = 1'b1; enable = 1'b0; cfg_we = 1'b0; ram_const_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cfg(input int v, input int sel, input int data);
    cfg_we = 1'b1; cfg_voice = 2'(v); cfg_sel = 2'(sel); cfg_data = 16'(data);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_rclk(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (RCLK === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    do_reset;
    vectors++; if (RADDR !== 8'h00) begin miscompares++; $display("FAIL reset_raddr: got %h expected 00", RADDR); end
    vectors++; if (rbank !== 2'd0) begin miscompares++; $display("FAIL reset_rbank: got %h expected 0", rbank); end
    vectors++; if (RCLK !== 1'b0) begin miscompares++; $display("FAIL reset_rclk: got %b expected 0", RCLK); end
    vectors++; if (dout !== 16'h8000) begin miscompares++; $display("FAIL reset_dout: got %h expected 8000", dout); end
    vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL reset_dvalid: got %b expected 0", dout_valid); end
    vectors++; if (SUB_OUT !== 4'h0 || overrun !== 4'h0) begin miscompares++; $display("FAIL reset_sub_ovr: got %h/%h expected 0/0", SUB_OUT, overrun); end
  endtask

  task automatic test_single_voice;
    bit seen; int t0;
    do_reset;
    cfg(0, 0, 15); cfg(0, 1, 0); cfg(0, 3, 16);
    enable = 1'b1; t0 = cyc;
    for (int k = 0; k < 3; k++) begin
      wait_rclk(40, seen);
      vectors++; if (!seen) begin miscompares++; $display("FAIL single_rclk%0d: no strobe within 40 cycles", k); return; end
      // 16 edges after enabling: RCLK sits in the 17th enabled cycle, then every 16
      vectors++; if (cyc - t0 != 16) begin miscompares++; $display("FAIL single_period%0d: got %0d expected 16", k, cyc - t0); end
      t0 = cyc;
      vectors++; if (RADDR !== 8'(k) || rbank !== 2'd0) begin miscompares++; $display("FAIL single_addr%0d: got %h/%h expected %h/0", k, RADDR, rbank, 8'(k)); end
      repeat (3) @(negedge clk);
      vectors++; if (dout_valid !== 1'b1 || dout !== (16'h8000 | 16'(k))) begin miscompares++; $display("FAIL single_dout%0d: got %b/%h expected 1/%h", k, dout_valid, dout, 16'h8000 | 16'(k)); end
      @(negedge clk);
      vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL single_pulse%0d: got %b expected 0", k, dout_valid); end
    end
  endtask

  task automatic test_step_sweep;
    bit seen;
    do_reset;
    cfg(0, 0, 3); cfg(0, 1, 3); cfg(0, 3, 16);
    enable = 1'b1;
    for (int k = 0; k <= 64; k++) begin
      wait_rclk(12, seen);
      vectors++; if (!seen) begin miscompares++; $display("FAIL sweep_rclk%0d: no strobe", k); return; end
      vectors++; if (RADDR !== 8'(4 * k)) begin miscompares++; $display("FAIL sweep_addr%0d: got %h expected %h", k, RADDR, 8'(4 * k)); end
      vectors++; if (rbank !== ((k == 64) ? 2'd1 : 2'd0)) begin miscompares++; $display("FAIL sweep_bank%0d: got %0d expected %0d", k, rbank, (k == 64) ? 1 : 0); end
      if (k == 63) begin
        vectors++; if (SUB_OUT[0] !== 1'b0) begin miscompares++; $display("FAIL sweep_sub_before: got %b expected 0", SUB_OUT[0]); end
      end
      if (k == 64) begin
        vectors++; if (SUB_OUT[0] !== 1'b1) begin miscompares++; $display("FAIL sweep_sub_after: got %b expected 1", SUB_OUT[0]); end
      end
      if (k == 20) cfg(0, 2, 1);
    end
    repeat (3) @(negedge clk);
    vectors++; if (dout_valid !== 1'b1 || dout !== 16'h8100) begin miscompares++; $display("FAIL sweep_bank_dout: got %b/%h expected 1/8100", dout_valid, dout); end
  endtask

  task automatic run_pair(input string name, input logic [15:0] ram, input int l0, input int l1,
                          input logic [15:0] exp1, input logic [15:0] exp2);
    bit seen;
    do_reset;
    ram_const_en = 1'b1; ram_const = ram;
    cfg(0, 0, 15); cfg(0, 3, l0);
    cfg(1, 0, 15); cfg(1, 3, l1);
    enable = 1'b1;
    wait_rclk(40, seen);
    vectors++; if (!seen) begin miscompares++; $display("FAIL %s_rclk: no strobe", name); return; end
    repeat (3) @(negedge clk);
    vectors++; if (RCLK !== 1'b1) begin miscompares++; $display("FAIL %s_second_rclk: got %b expected 1", name, RCLK); end
    vectors++; if (dout_valid !== 1'b1 || dout !== exp1) begin miscompares++; $display("FAIL %s_dout1: got %b/%h expected 1/%h", name, dout_valid, dout, exp1); end
    repeat (3) @(negedge clk);
    vectors++; if (dout_valid !== 1'b1 || dout !== exp2) begin miscompares++; $display("FAIL %s_dout2: got %b/%h expected 1/%h", name, dout_valid, dout, exp2); end
    vectors++; if (overrun !== 4'h0) begin miscompares++; $display("FAIL %s_overrun: got %h expected 0", name, overrun); end
  endtask

  task automatic test_back_to_back;
    run_pair("sat_pos", 16'h7FFF, 16, 16, 16'hFFFF, 16'hFFFF);
    run_pair("half",    16'h7FFF, 8,  8,  16'hBFFF, 16'hFFFE);
    run_pair("order",   16'h7FFF, 4,  16, 16'h9FFF, 16'hFFFF);
    run_pair("clamp",   16'h7FFF, 31, 0,  16'hFFFF, 16'hFFFF);
    run_pair("sat_neg", 16'h8001, 16, 16, 16'h0001, 16'h0000);
    run_pair("neg_half",16'h8001, 8,  0,  16'h4000, 16'h4000);
  endtask

  task automatic test_overrun;
    int n;
    do_reset;
    for (int v = 0; v < 4; v++) cfg(v, 0, 1);
    enable = 1'b1;
    repeat (20) @(negedge clk);
    vectors++; if (overrun !== 4'hF) begin miscompares++; $display("FAIL overrun_set: got %h expected f", overrun); end
    enable = 1'b0;
    repeat (10) @(negedge clk);
    vectors++; if (overrun !== 4'hF) begin miscompares++; $display("FAIL overrun_sticky: got %h expected f", overrun); end
    do_reset;
    vectors++; if (overrun !== 4'h0) begin miscompares++; $display("FAIL overrun_clear: got %h expected 0", overrun); end
    enable = 1'b1; n = 0;
    repeat (60) begin @(negedge clk); if (RCLK === 1'b1) n++; end
    vectors++; if (n != 0) begin miscompares++; $display("FAIL fs0_silent: got %0d strobes expected 0", n); end
  endtask

  task automatic test_enable_drop;
    bit seen; int n; int t0;
    do_reset;
    cfg(0, 0, 15); cfg(0, 3, 16);
    enable = 1'b1;
    wait_rclk(40, seen);
    vectors++; if (!seen) begin miscompares++; $display("FAIL edrop_rclk: no strobe"); return; end
    enable = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (dout_valid !== 1'b1 || dout !== 16'h8000) begin miscompares++; $display("FAIL edrop_inflight: got %b/%h expected 1/8000", dout_valid, dout); end
    n = 0;
    repeat (100) begin @(negedge clk); if (RCLK === 1'b1 || dout_valid === 1'b1) n++; end
    vectors++; if (n != 0) begin miscompares++; $display("FAIL edrop_frozen: got %0d events expected 0", n); end
    enable = 1'b1; t0 = cyc;
    wait_rclk(40, seen);
    vectors++; if (!seen) begin miscompares++; $display("FAIL edrop_resume: no strobe"); return; end
    vectors++; if (cyc - t0 != 16 || RADDR !== 8'h01) begin miscompares++; $display("FAIL edrop_phase: got %0d/%h expected 16/01", cyc - t0, RADDR); end
    repeat (3) @(negedge clk);
    vectors++; if (dout !== 16'h8001) begin miscompares++; $display("FAIL edrop_dout: got %h expected 8001", dout); end
  endtask

  task automatic test_reset_mid_read;
    bit seen;
    do_reset;
    ram_const_en = 1'b1; ram_const = 16'h1234;
    cfg(0, 0, 3); cfg(0, 1, 7); cfg(0, 3, 16);
    enable = 1'b1;
    for (int k = 0; k <= 33; k++) begin
      wait_rclk(12, seen);
      if (!seen) begin vectors++; miscompares++; $display("FAIL rstmid_rclk%0d: no strobe", k); return; end
    end
    vectors++; if (SUB_OUT[0] !== 1'b1 || RADDR !== 8'h08) begin miscompares++; $display("FAIL rstmid_pre: got %b/%h expected 1/08", SUB_OUT[0], RADDR); end
    @(negedge clk);
    vectors++; if (dout !== 16'h9234) begin miscompares++; $display("FAIL rstmid_dout_pre: got %h expected 9234", dout); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (RCLK !== 1'b0 || RADDR !== 8'h00) begin miscompares++; $display("FAIL rstmid_bus: got %b/%h expected 0/00", RCLK, RADDR); end
    vectors++; if (dout !== 16'h8000 || dout_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_dout: got %h/%b expected 8000/0", dout, dout_valid); end
    vectors++; if (SUB_OUT !== 4'h0) begin miscompares++; $display("FAIL rstmid_sub: got %h expected 0", SUB_OUT); end
    rst = 1'b0; enable = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single_voice;
    test_step_sweep;
    test_back_to_back;
    test_overrun;
    test_enable_drop;
    test_reset_mid_read;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
